// File: rtl/forest_pkg.sv
// Shared opcodes, vote FSM encoding and width helpers for the forest front end.
// The FOREST_TIMEOUT_EN build option is implemented in forest_vote_tally.
package forest_pkg;

  localparam int OP_NOP        = 0;
  localparam int OP_LOAD_THRES = 1;
  localparam int OP_CLASSIFY   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_TALLY,
    S_ARGMAX,
    S_DONE
  } state_t;

  function automatic int tidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/forest_dispatch_vote_if.sv
// Instruction stream handshake from the control core into the forest front end.
// master = instruction source, slave = forest_dispatch_vote.
interface forest_dispatch_vote_if
  import forest_pkg::*;
#(
  parameter int N_TREES = 8,
  parameter int OP_W    = 5,
  parameter int NODE_W  = 8,
  parameter int THRES_W = 32
);
  localparam int TIDX_W = tidx_w(N_TREES);

  logic               instr_valid_i;
  logic               instr_ready_o;
  logic               instr_bcast_i;
  logic [TIDX_W-1:0]  instr_tree_i;
  logic [OP_W-1:0]    instr_op_i;
  logic [NODE_W-1:0]  instr_node_i;
  logic [THRES_W-1:0] instr_thres_i;

  modport master (
    output instr_valid_i, instr_bcast_i, instr_tree_i,
    output instr_op_i, instr_node_i, instr_thres_i,
    input  instr_ready_o
  );

  modport slave (
    input  instr_valid_i, instr_bcast_i, instr_tree_i,
    input  instr_op_i, instr_node_i, instr_thres_i,
    output instr_ready_o
  );

endinterface

// File: rtl/forest_vote_tally.sv
// Decision collection, per-class tally and sequential argmax vote.
// FOREST_TIMEOUT_EN adds a COLLECT timeout that votes with partial masks.
module forest_vote_tally
  import forest_pkg::*;
#(
  parameter int N_TREES     = 8,
  parameter int CLASS_W     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_TREES-1:0]          dec_valid,
  input  logic [N_TREES*CLASS_W-1:0]  dec_class,
  output logic                        busy,
  output logic                        vote_valid,
  output logic [CLASS_W-1:0]          vote_class,
  output logic [cnt_w(N_TREES)-1:0]   vote_count,
  output logic                        vote_tie,
  output logic                        overrun
);
  localparam int TIDX_W  = tidx_w(N_TREES);
  localparam int CNT_W   = cnt_w(N_TREES);
  localparam int N_CLASS = 2 ** CLASS_W;

  state_t state, state_nx;

  logic [N_TREES-1:0] mask, fresh, mask_nx;
  logic [CLASS_W-1:0] cls [N_TREES];
  logic [CNT_W-1:0]   cnt [N_CLASS];
  logic [TIDX_W-1:0]  tidx;
  logic [CLASS_W-1:0] cidx, best_class;
  logic [CNT_W-1:0]   best_cnt;
  logic               tie, open_win, expired, done;

  assign open_win = (state == S_IDLE) || (state == S_COLLECT);
  assign fresh    = dec_valid & ~mask;
  assign mask_nx  = mask | fresh;
  assign done     = (state == S_DONE);

`ifdef FOREST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tcnt <= '0;
    else if (state == S_COLLECT) tcnt <= tcnt + 1'b1;
    else                        tcnt <= '0;
  end

  assign expired  = (state == S_COLLECT) && (tcnt == TO_W'(TIMEOUT_CYC - 1));
  assign vote_tie = done & (tie | ~&mask);
`else
  // constant-false: COLLECT waits forever and no counter exists
  assign expired  = (TIMEOUT_CYC < 0);
  assign vote_tie = done & tie;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (|dec_valid)
          state_nx = (&mask_nx) ? S_TALLY : S_COLLECT;
      S_COLLECT:
        if ((&mask_nx) || expired) state_nx = S_TALLY;
      S_TALLY:
        if (tidx == TIDX_W'(N_TREES - 1)) state_nx = S_ARGMAX;
      S_ARGMAX:
        if (&cidx) state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask       <= '0;
      tidx       <= '0;
      cidx       <= '0;
      best_class <= '0;
      best_cnt   <= '0;
      tie        <= 1'b0;
      overrun    <= 1'b0;
      for (int k = 0; k < N_TREES; k++) cls[k] <= '0;
      for (int c = 0; c < N_CLASS; c++) cnt[c] <= '0;
    end else begin
      if (open_win) begin
        mask <= mask_nx;
        for (int k = 0; k < N_TREES; k++)
          if (fresh[k]) cls[k] <= dec_class[k*CLASS_W +: CLASS_W];
      end else if (|dec_valid) begin
        overrun <= 1'b1;
      end
      case (state)
        S_TALLY: begin
          if (mask[tidx] && (cnt[cls[tidx]] != CNT_W'(N_TREES)))
            cnt[cls[tidx]] <= cnt[cls[tidx]] + 1'b1;
          tidx <= (tidx == TIDX_W'(N_TREES - 1)) ? '0 : tidx + 1'b1;
        end
        S_ARGMAX: begin
          cidx <= cidx + 1'b1;
          if (cnt[cidx] > best_cnt) begin
            best_class <= cidx;
            best_cnt   <= cnt[cidx];
            tie        <= 1'b0;
          end else if ((cnt[cidx] == best_cnt) && (best_cnt != '0)) begin
            tie <= 1'b1;
          end
        end
        S_DONE: begin
          mask       <= '0;
          best_class <= '0;
          best_cnt   <= '0;
          tie        <= 1'b0;
          for (int c = 0; c < N_CLASS; c++) cnt[c] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == S_TALLY) || (state == S_ARGMAX);
  assign vote_valid = done;
  assign vote_class = done ? best_class : '0;
  assign vote_count = done ? best_cnt : '0;

endmodule

// File: rtl/forest_dispatch_vote.sv
// Forest front end: instruction decode into per-tree command banks plus vote.
// Build with FOREST_TIMEOUT_EN to bound the decision collect window.
module forest_dispatch_vote
  import forest_pkg::*;
#(
  parameter int N_TREES     = 8,
  parameter int OP_W        = 5,
  parameter int NODE_W      = 8,
  parameter int THRES_W     = 32,
  parameter int CLASS_W     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  forest_dispatch_vote_if.slave        instr,
  output logic [N_TREES*OP_W-1:0]      tree_op_o,
  output logic [N_TREES*NODE_W-1:0]    tree_node_o,
  output logic [N_TREES*THRES_W-1:0]   tree_thres_o,
  output logic [N_TREES-1:0]           tree_cmd_valid_o,
  input  logic [N_TREES-1:0]           tree_dec_valid_i,
  input  logic [N_TREES*CLASS_W-1:0]   tree_class_i,
  output logic                         vote_valid_o,
  output logic [CLASS_W-1:0]           vote_class_o,
  output logic [cnt_w(N_TREES)-1:0]    vote_count_o,
  output logic                         vote_tie_o,
  output logic                         overrun_o
);
  localparam int TIDX_W = tidx_w(N_TREES);

  logic               busy, ready, accept;
  logic [N_TREES-1:0] sel;

  assign ready              = ~busy;
  assign instr.instr_ready_o = ready;
  assign accept             = instr.instr_valid_i & ready;

  // an out-of-range index matches no k, so it is consumed silently
  always_comb begin
    sel = '0;
    for (int k = 0; k < N_TREES; k++)
      sel[k] = accept &
               (instr.instr_bcast_i | (instr.instr_tree_i == TIDX_W'(k)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_cmd_valid_o <= '0;
      tree_op_o        <= {N_TREES{OP_W'(OP_NOP)}};
      tree_node_o      <= '0;
      tree_thres_o     <= '0;
    end else begin
      tree_cmd_valid_o <= sel;
      for (int k = 0; k < N_TREES; k++) begin
        if (sel[k]) begin
          tree_op_o[k*OP_W +: OP_W]          <= instr.instr_op_i;
          tree_node_o[k*NODE_W +: NODE_W]    <= instr.instr_node_i;
          tree_thres_o[k*THRES_W +: THRES_W] <= instr.instr_thres_i;
        end
      end
    end
  end

  forest_vote_tally #(
    .N_TREES     (N_TREES),
    .CLASS_W     (CLASS_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tally (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (tree_dec_valid_i),
    .dec_class  (tree_class_i),
    .busy       (busy),
    .vote_valid (vote_valid_o),
    .vote_class (vote_class_o),
    .vote_count (vote_count_o),
    .vote_tie   (vote_tie_o),
    .overrun    (overrun_o)
  );

endmodule

// File: tb/tb_forest_dispatch_vote.sv
// Randomised bench for forest_dispatch_vote with a schedule-level vote model
// and directed cases for dispatch, majority, tie, overrun, reset and timeout.
module tb_forest_dispatch_vote;
  localparam int N = 8, OW = 5, NW = 8, TW = 32, CW = 4;
  localparam int NC = 16, LAT = N + NC + 1, TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forest_dispatch_vote_if #(.N_TREES(N), .OP_W(OW), .NODE_W(NW), .THRES_W(TW)) bus ();

  logic [N*OW-1:0] t_op;
  logic [N*NW-1:0] t_node;
  logic [N*TW-1:0] t_thr;
  logic [N-1:0]    cmd, dec_valid;
  logic [N*CW-1:0] dec_class;
  logic            vv, vt, ovr;
  logic [CW-1:0]   vc;
  logic [3:0]      vn;

  forest_dispatch_vote #(
    .N_TREES(N), .OP_W(OW), .NODE_W(NW), .THRES_W(TW),
    .CLASS_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .instr(bus),
    .tree_op_o(t_op), .tree_node_o(t_node), .tree_thres_o(t_thr),
    .tree_cmd_valid_o(cmd), .tree_dec_valid_i(dec_valid),
    .tree_class_i(dec_class), .vote_valid_o(vv), .vote_class_o(vc),
    .vote_count_o(vn), .vote_tie_o(vt), .overrun_o(ovr)
  );

  int passed = 0, total = 0, strobes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // model: tree banks, received decisions, and position in the vote schedule
  logic [OW-1:0] m_op [N];
  logic [NW-1:0] m_node [N];
  logic [TW-1:0] m_thr [N];
  logic [N-1:0]  m_cmd, rmask;
  int            rcls [N];
  int            pos, ccnt, e_cls, e_cnt;
  bit            e_tie, m_ovr;

  task automatic resolve();
    int cnts [NC];
    int best, nbest;
    foreach (cnts[c]) cnts[c] = 0;
    for (int k = 0; k < N; k++) if (rmask[k]) cnts[rcls[k]]++;
    best = 0; e_cls = 0;
    for (int c = 0; c < NC; c++) if (cnts[c] > best) begin best = cnts[c]; e_cls = c; end
    nbest = 0;
    for (int c = 0; c < NC; c++) if (cnts[c] == best) nbest++;
    e_cnt = best;
    e_tie = (best > 0 && nbest > 1) || (rmask != '1);
    pos = 1; rmask = '0; ccnt = 0;
  endtask

  task automatic model_edge();
    bit busy_pre, started;
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_op[k] = '0; m_node[k] = '0; m_thr[k] = '0; end
      m_cmd = '0; rmask = '0; pos = 0; ccnt = 0; m_ovr = 0;
      e_cls = 0; e_cnt = 0; e_tie = 0;
      return;
    end
    busy_pre = (pos >= 1) && (pos <= LAT - 1);
    m_cmd = '0;
    if (bus.instr_valid_i && !busy_pre)
      for (int k = 0; k < N; k++)
        if (bus.instr_bcast_i || bus.instr_tree_i == k) begin
          m_op[k] = bus.instr_op_i; m_node[k] = bus.instr_node_i;
          m_thr[k] = bus.instr_thres_i; m_cmd[k] = 1'b1;
        end
    if (pos != 0) begin
      if (|dec_valid) m_ovr = 1;
      pos = (pos == LAT) ? 0 : pos + 1;
    end else begin
      started = (rmask != '0);
      for (int k = 0; k < N; k++)
        if (dec_valid[k] && !rmask[k]) begin
          rmask[k] = 1'b1;
          rcls[k] = int'(dec_class[k*CW +: CW]);
        end
      if (rmask == '1) resolve();
`ifdef FOREST_TIMEOUT_EN
      else if (started && ccnt == TO - 1) resolve();
      else if (started) ccnt++;
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin : compare
    logic [N*OW-1:0] eo;
    logic [N*NW-1:0] en;
    if (!rst) begin
      if (vv) strobes++;
      chk("vote_valid", vv, pos == LAT);
      if (pos == LAT) begin
        chk("vote_class", vc, e_cls);
        chk("vote_count", vn, e_cnt);
        chk("vote_tie", vt, e_tie);
      end
      chk("ready", bus.instr_ready_o, !((pos >= 1) && (pos <= LAT - 1)));
      chk("overrun", ovr, m_ovr);
      chk("cmd_valid", cmd, m_cmd);
      for (int k = 0; k < N; k++) begin
        eo[k*OW +: OW] = m_op[k];
        en[k*NW +: NW] = m_node[k];
        chk("thres", t_thr[k*TW +: TW], m_thr[k]);
      end
      chk("op", t_op, eo);
      chk("node", t_node, en);
    end
  end

  task automatic deliver(input logic [N-1:0] m, input logic [N*CW-1:0] c);
    dec_valid = m; dec_class = c;
    cycle();
    dec_valid = '0;
  endtask

  task automatic wait_vote(output int n, output int rdy_hi);
    n = 0; rdy_hi = 0;
    while (n < 200) begin
      cycle();
      n++;
      if (vv) break;
      if (bus.instr_ready_o) rdy_hi++;
    end
    if (!vv) chk("vote_timeout", 0, 1);
  endtask

  localparam logic [31:0] MAJ = 32'h7512_2555;
  localparam logic [31:0] TIE = 32'h6666_3333;

  int n, rh, seen;
  logic [N*OW-1:0] all2;

  initial begin
    rst = 1'b1;
    dec_valid = '0; dec_class = '0;
    bus.instr_valid_i = 0; bus.instr_bcast_i = 0; bus.instr_tree_i = '0;
    bus.instr_op_i = '0; bus.instr_node_i = '0; bus.instr_thres_i = '0;
    cycle(); cycle();
    chk("rst_op", t_op, 0);
    chk("rst_vv", vv, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_ready", bus.instr_ready_o, 1);
    rst = 1'b0;
    cycle();

    bus.instr_valid_i = 1; bus.instr_tree_i = 3; bus.instr_op_i = 1;
    bus.instr_node_i = 8'h12; bus.instr_thres_i = 32'hDEADBEEF;
    cycle();
    bus.instr_valid_i = 0;
    chk("uni_cmd", cmd, 8'h08);
    chk("uni_op_vec", t_op, 40'h8000);
    chk("uni_node_vec", t_node, 64'h1200_0000);
    chk("uni_thres3", t_thr[3*TW +: TW], 32'hDEADBEEF);
    chk("uni_thres_lo", t_thr[63:0], 0);
    cycle();
    chk("uni_cmd_once", cmd, 0);

    bus.instr_valid_i = 1; bus.instr_bcast_i = 1; bus.instr_tree_i = 5;
    bus.instr_op_i = 2; bus.instr_node_i = 0; bus.instr_thres_i = 0;
    cycle();
    bus.instr_valid_i = 0; bus.instr_bcast_i = 0;
    all2 = {N{5'd2}};
    chk("bc_cmd", cmd, 8'hFF);
    chk("bc_op", t_op, all2);
    cycle();
    chk("bc_cmd_once", cmd, 0);

    deliver(8'h07, MAJ); deliver(8'h38, MAJ); deliver(8'hC0, MAJ);
    wait_vote(n, rh);
    chk("maj_latency", n + 1, LAT);
    chk("maj_ready_low", rh, 0);
    chk("maj_class", vc, 5);
    chk("maj_count", vn, 4);
    chk("maj_tie", vt, 0);
    cycle();

    deliver(8'hFF, TIE);
    wait_vote(n, rh);
    chk("tie_class", vc, 3);
    chk("tie_count", vn, 4);
    chk("tie_tie", vt, 1);
    cycle();

    deliver(8'h07, MAJ); deliver(8'h38, MAJ); deliver(8'hC0, MAJ);
    cycle(); cycle(); cycle();
    deliver(8'h10, 32'hFFFF_FFFF);
    chk("ovr_set", ovr, 1);
    wait_vote(n, rh);
    chk("ovr_class", vc, 5);
    chk("ovr_count", vn, 4);
    cycle();

    deliver(8'hFF, TIE);
    for (int i = 0; i < 12; i++) cycle();
    rst = 1'b1;
    #1;
    chk("arst_vv", vv, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_op", t_op, 0);
    chk("arst_class", vc, 0);
    cycle();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin cycle(); if (vv) seen++; end
    chk("arst_no_strobe", seen, 0);

`ifdef FOREST_TIMEOUT_EN
    deliver(8'h3F, 32'h4444_4444);
    wait_vote(n, rh);
    chk("to_latency", n, TO + N + NC);
    chk("to_class", vc, 4);
    chk("to_count", vn, 6);
    chk("to_tie", vt, 1);
    cycle();
`endif

    for (int i = 0; i < 3000; i++) begin
      bus.instr_valid_i = 1'($urandom_range(0, 1));
      bus.instr_bcast_i = ($urandom_range(0, 4) == 0);
      bus.instr_tree_i  = 3'($urandom_range(0, N - 1));
      bus.instr_op_i    = 5'($urandom);
      bus.instr_node_i  = 8'($urandom);
      bus.instr_thres_i = $urandom;
      dec_valid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : '0;
      for (int k = 0; k < N; k++)
        dec_class[k*CW +: CW] = ((i / 200) % 2 == 0) ?
          4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cycle();
    end
    bus.instr_valid_i = 0;
    dec_valid = '0;
    cycle();
    chk("strobes_seen", strobes > 20, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
